// File: rtl/muldiv32.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// One 33-bit add/subtract per iteration; signed ops run on magnitudes and are sign-fixed at the end.
module muldiv32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state, state_nxt;
   logic [4:0]       cnt;
   logic             div_op, neg_q, neg_r;
   logic [WIDTH-1:0] p_hi, p_lo, m;

   logic             launch, div_by_zero;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   mul_sum, r_sh, diff;

   assign launch      = start && !busy;
   assign div_by_zero = op[1] && (B == '0);
   assign abs_a       = (op[0] && A[WIDTH-1]) ? -A : A;
   assign abs_b       = (op[0] && B[WIDTH-1]) ? -B : B;

   // Multiply: conditional add into P_hi with carry; divide: trial subtract on shifted remainder.
   assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
   assign r_sh    = {p_hi, p_lo[WIDTH-1]};
   assign diff    = r_sh - {1'b0, m};

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start)            state_nxt = div_by_zero ? DONE : CALC;
            else if (state == DONE) state_nxt = IDLE;
         end
         CALC:    if (cnt == 5'd31) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == CALC) || (state_nxt == FIX);
         done  <= (state_nxt == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         div_op   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         p_hi     <= '0;
         p_lo     <= '0;
         m        <= '0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         if (!busy) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
         if (launch) begin
            div_op   <= op[1];
            neg_q    <= op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r    <= op[0] & A[WIDTH-1];
            cnt      <= '0;
            div_zero <= 1'b0;
            p_hi     <= '0;
            p_lo     <= op[1] ? abs_a : abs_b;
            m        <= op[1] ? abs_b : abs_a;
            // Zero divisor finishes at launch and overrides a coincident move write.
            if (div_by_zero) begin
               hi       <= A;
               lo       <= '1;
               div_zero <= 1'b1;
            end
         end else if (state == CALC) begin
            cnt <= cnt + 5'd1;
            if (div_op) begin
               p_lo <= {p_lo[WIDTH-2:0], ~diff[WIDTH]};
               p_hi <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            end else begin
               p_hi <= mul_sum[WIDTH:1];
               p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
            end
         end else if (state == FIX) begin
            if (div_op) begin
               lo <= neg_q ? -p_lo : p_lo;
               hi <= neg_r ? -p_hi : p_hi;
            end else begin
               {hi, lo} <= neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv32.sv
// Self-checking bench for muldiv32: directed test-plan cases plus random ops against an arithmetic model.
module tb_muldiv32;

   logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] A = '0, B = '0, wdata = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int          total = 0, passed = 0;
   logic [31:0] e_hi, e_lo, h0, l0;
   logic        e_dz;

   muldiv32 #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: plain 64-bit arithmetic, truncating signed division.
   task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic d);
      logic [63:0] p;
      longint      sa, sb, q, r;
      d = 1'b0;
      h = '0;
      l = '0;
      if (o == 2'd0) begin
         p = {32'd0, a} * {32'd0, b};
         {h, l} = p;
      end else if (o == 2'd1) begin
         p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         {h, l} = p;
      end else if (b == 32'd0) begin
         h = a;
         l = 32'hFFFF_FFFF;
         d = 1'b1;
      end else if (o == 2'd2) begin
         l = a / b;
         h = a % b;
      end else begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         q  = sa / sb;
         r  = sa % sb;
         l  = q[31:0];
         h  = r[31:0];
      end
   endtask

   // Called at a negedge; returns at the first negedge after the launch edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      model(o, a, b, e_hi, e_lo, e_dz);
      h0 = hi;
      l0 = lo;
      op = o; A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int inject_at);
      int c = 1;
      int bc = 0;
      bit unstable = 1'b0;
      while (!done && c < 60) begin
         if (busy) bc++;
         if (hi !== h0 || lo !== l0) unstable = 1'b1;
         if (c == inject_at) begin
            start = 1'b1; op = 2'b11; A = 32'h1234; B = 32'h7;
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
         end
         @(negedge clk);
         if (c == inject_at) begin
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
         end
         c++;
      end
      check({tag, " latency"}, c, e_dz ? 1 : 34);
      check({tag, " busy_cycles"}, bc, e_dz ? 0 : 33);
      check({tag, " hilo_stable"}, unstable, 0);
      check({tag, " hi"}, hi, e_hi);
      check({tag, " lo"}, lo, e_lo);
      check({tag, " div_zero"}, div_zero, e_dz);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst div_zero", div_zero, 0);
      check("rst hi", hi, 0);
      check("rst lo", lo, 0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu_max", 0);
      check("multu_max hi const", hi, 32'hFFFF_FFFE);
      check("multu_max lo const", lo, 32'h0000_0001);
      @(negedge clk);
      check("done pulse width", done, 0);
      check("idle busy", busy, 0);

      issue(2'd1, 32'hFFFF_FFFD, 32'd7);
      wait_done("mult_neg", 0);
      check("mult_neg lo const", lo, 32'hFFFF_FFEB);

      // Launch in the done cycle: busy rises while done drops.
      issue(2'd3, 32'hFFFF_FFF9, 32'd2);
      check("b2b busy", busy, 1);
      check("b2b done", done, 0);
      wait_done("div_neg", 0);
      check("div_neg lo const", lo, 32'hFFFF_FFFD);

      @(negedge clk);
      issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 0);
      check("div_ovf lo const", lo, 32'h8000_0000);

      @(negedge clk);
      issue(2'd2, 32'd100, 32'd0);
      wait_done("divu_zero", 0);
      @(negedge clk);
      check("divu_zero held", div_zero, 1);
      check("divu_zero after done", done, 0);

      issue(2'd0, 32'hDEAD_BEEF, 32'h0123_4567);
      wait_done("inject", 5);

      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h1234_5678;
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi idle", hi, 32'h1234_5678);

      issue(2'd0, 32'h0BAD_F00D, 32'h7777_1234);
      repeat (9) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("async rst busy", busy, 0);
      check("async rst done", done, 0);
      check("async rst hi", hi, 0);
      check("async rst lo", lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(2'd0, 32'd3, 32'd5);
      wait_done("post_rst", 0);

      for (int i = 0; i < 30; i++) begin
         logic [1:0]  ro;
         logic [31:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         issue(ro, ra, rb);
         wait_done($sformatf("rand%0d op%0d", i, ro), 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
